// File: rtl/l2_ram_banked_pipe.sv
// rtl/l2_ram_banked_pipe.sv - banked L2 RAM with range check, read pipeline and zero-init sweep
module l2_ram_banked_pipe #(
    parameter int          NB_BANKS      = 4,
    parameter int          BANK_WORDS    = 32768,
    parameter int          DATA_WIDTH    = 32,
    parameter logic [31:0] BASE_ADDR     = 32'h1C010000,
    parameter int          READ_LATENCY  = 1,
    parameter bit          INIT_ON_RESET = 1'b1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NB_BANKS-1:0]              req_i,
    output logic [NB_BANKS-1:0]              gnt_o,
    input  logic [NB_BANKS*32-1:0]           add_i,
    input  logic [NB_BANKS-1:0]              wen_i,
    input  logic [NB_BANKS*DATA_WIDTH/8-1:0] be_i,
    input  logic [NB_BANKS*DATA_WIDTH-1:0]   wdata_i,
    output logic [NB_BANKS-1:0]              r_valid_o,
    output logic [NB_BANKS-1:0]              r_opc_o,
    output logic [NB_BANKS*DATA_WIDTH-1:0]   r_rdata_o,
    output logic                             init_done_o
);
    localparam int          LB     = $clog2(NB_BANKS);
    localparam int          LW     = $clog2(BANK_WORDS);
    localparam int          NBYTES = DATA_WIDTH / 8;
    localparam logic [63:0] RANGE  = 64'(NB_BANKS) * 64'(BANK_WORDS) * 64'd4;

    function automatic logic [DATA_WIDTH-1:0] f_bad_pattern();
        logic [31:0] pat;
        pat = 32'hBADACCE5;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            f_bad_pattern[i] = pat[i[4:0]];
        end
    endfunction

    localparam logic [DATA_WIDTH-1:0] BAD_DATA = f_bad_pattern();

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [LW-1:0]   r_init_cnt;
    logic            w_init;
    logic [NB_BANKS-1:0] w_gnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= INIT_ON_RESET ? S_INIT : S_RUN;
            r_init_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_INIT) begin
                r_init_cnt <= r_init_cnt + LW'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == S_INIT && r_init_cnt == LW'(BANK_WORDS - 1)) begin
            w_state_nxt = S_RUN;
        end
    end

    assign w_init      = (r_state == S_INIT) && !rst_i;
    assign w_gnt       = (r_state == S_RUN) ? req_i : '0;
    assign gnt_o       = w_gnt;
    assign init_done_o = (r_state == S_RUN);

    for (genvar p = 0; p < NB_BANKS; p++) begin : g_bank
        logic [31:0]           w_off;
        logic [LW-1:0]         w_row;
        logic                  w_in_range;
        logic                  w_we;
        logic [LW-1:0]         w_wrow;
        logic [NBYTES-1:0]     w_wbe;
        logic [DATA_WIDTH-1:0] w_wdata;
        logic [DATA_WIDTH-1:0] r_mem [BANK_WORDS];
        logic [READ_LATENCY-1:0] r_pv;
        logic [READ_LATENCY-1:0] r_popc;
        logic [DATA_WIDTH-1:0] r_pd [READ_LATENCY];

        // Addresses below BASE_ADDR wrap to huge offsets and fall out of range.
        assign w_off      = add_i[32*p +: 32] - BASE_ADDR;
        assign w_row      = w_off[LB+LW+1 : LB+2];
        assign w_in_range = {32'd0, w_off} < RANGE;

        assign w_we    = w_init || (w_gnt[p] && w_in_range && !wen_i[p] && !rst_i);
        assign w_wrow  = w_init ? r_init_cnt : w_row;
        assign w_wbe   = w_init ? '1 : be_i[NBYTES*p +: NBYTES];
        assign w_wdata = w_init ? '0 : wdata_i[DATA_WIDTH*p +: DATA_WIDTH];

        always_ff @(posedge clk_i) begin
            if (w_we) begin
                for (int b = 0; b < NBYTES; b++) begin
                    if (w_wbe[b]) begin
                        r_mem[w_wrow][8*b +: 8] <= w_wdata[8*b +: 8];
                    end
                end
            end
        end

        // Data stages load only behind a valid so the output holds between responses.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_pv   <= '0;
                r_popc <= '0;
                for (int k = 0; k < READ_LATENCY; k++) begin
                    r_pd[k] <= '0;
                end
            end else begin
                r_pv[0]   <= w_gnt[p];
                r_popc[0] <= w_gnt[p] && !w_in_range;
                if (w_gnt[p]) begin
                    r_pd[0] <= w_in_range ? r_mem[w_row] : BAD_DATA;
                end
                for (int k = 1; k < READ_LATENCY; k++) begin
                    r_pv[k]   <= r_pv[k-1];
                    r_popc[k] <= r_popc[k-1];
                    if (r_pv[k-1]) begin
                        r_pd[k] <= r_pd[k-1];
                    end
                end
            end
        end

        assign r_valid_o[p]                          = r_pv[READ_LATENCY-1];
        assign r_opc_o[p]                            = r_popc[READ_LATENCY-1];
        assign r_rdata_o[DATA_WIDTH*p +: DATA_WIDTH] = r_pd[READ_LATENCY-1];
    end

endmodule

// File: doc/l2_ram_banked_pipe.md
Name: l2_ram_banked_pipe

Overview:
- Parametrised successor of the SoC L2 interleaved memory. Generalises bank count, bank depth, data width and read latency.
- Adds three things: out-of-range error responses, a configurable read-output pipeline, and a hardware zero-initialisation sweep after reset.
- Sits behind the SoC L2 interconnect. Each request port maps 1:1 to one bank, and the interconnect has already performed word interleaving.

Parameters:
- NB_BANKS, 4, number of banks/ports; power of two, 1..16.
- BANK_WORDS, 32768, words per bank; power of two, >= 4.
- DATA_WIDTH, 32, bits per word; multiple of 8.
- BASE_ADDR, 32'h1C010000, byte address of the first word of the interleaved region.
- READ_LATENCY, 1, cycles from grant to r_valid; 1..3.
- INIT_ON_RESET, 1, 1 = zero all banks after reset before granting.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_i  in  NB_BANKS  per-port request
- gnt_o  out  NB_BANKS  per-port grant
- add_i  in  NB_BANKS*32  per-port byte address; port p occupies slice [32p+31:32p]
- wen_i  in  NB_BANKS  1 = read, 0 = write
- be_i  in  NB_BANKS*DATA_WIDTH/8  byte enables, active-high
- wdata_i  in  NB_BANKS*DATA_WIDTH  write data
- r_valid_o  out  NB_BANKS  response valid
- r_opc_o  out  NB_BANKS  1 = error response
- r_rdata_o  out  NB_BANKS*DATA_WIDTH  read data
- init_done_o  out  1  high once banks are usable

Behaviour:
- Reset (rst_i sampled high on a clock edge):
  - gnt_o=0, r_valid_o=0, r_opc_o=0, r_rdata_o=0, the whole response pipeline cleared.
  - Init counter=0; state=INIT if INIT_ON_RESET=1, else RUN.
  - init_done_o=0 in INIT, 1 in RUN.
- FSM:
  - INIT: each cycle write all-zero, all bytes enabled, to row init_cnt of every bank; init_cnt increments.
  - INIT -> RUN after the write to row BANK_WORDS-1, so exactly BANK_WORDS cycles are spent in INIT.
  - RUN: terminal state until the next reset.
  - Reset asserted mid-INIT restarts the sweep at row 0.
- Grant: gnt_o[p] = req_i[p] when state=RUN, else 0; combinational. There is never any back-pressure in RUN.
- Address decode (per port):
  - off = add_i - BASE_ADDR, computed in 32-bit unsigned arithmetic; addresses below BASE_ADDR therefore wrap to large values.
  - row = off[log2(NB_BANKS)+log2(BANK_WORDS)+1 : log2(NB_BANKS)+2].
  - in_range = off < NB_BANKS*BANK_WORDS*4.
  - add_i[1:0] is ignored.
- Access: a granted, in-range request performs a read or byte-masked write of row in bank p at that clock edge.
  - A granted, out-of-range request does not touch memory.
- Response:
  - Exactly one response per granted request, READ_LATENCY cycles later. Latency 1 means r_valid_o is high in the cycle after the grant.
  - The pipeline is fully pipelined, so back-to-back requests give back-to-back responses.
  - In-range read: r_opc_o=0, r_rdata_o = memory word.
  - In-range write: r_opc_o=0, r_rdata_o don't-care.
  - Out-of-range (read or write): r_opc_o=1, r_rdata_o = 32'hBADACCE5 replicated to DATA_WIDTH.
  - r_rdata_o holds its last value when r_valid_o=0.
- Ordering: a read issued the cycle after a write to the same row returns the new data. Unenabled bytes keep their old value.
- Ports are independent: simultaneous accesses on all banks in the same cycle are all serviced.

Test Plan:
- Init sweep: BANK_WORDS=16, NB_BANKS=4, INIT_ON_RESET=1.
  - Assert req_i=4'hF from reset release -> gnt_o=0 for exactly 16 cycles, then init_done_o=1 and gnt_o=4'hF.
  - Read every row of every bank -> all 0.
- Write/read:
  - Port 1 writes 32'hDEADBEEF, be=4'hF, at BASE_ADDR+0x14 (row 1); next cycle, read the same address.
  - Required: r_valid 1 cycle after each grant; read returns 32'hDEADBEEF, r_opc=0.
- Byte enables:
  - Write 32'h11223344 be=4'hF, then 32'hAABBCCDD be=4'b0101, to the same row -> read returns 32'h11BB33DD.
- Latency/pipelining: READ_LATENCY=3, four back-to-back reads on port 0 -> r_valid_o[0] high on cycles 3..6 after the first grant, with data in request order.
- Errors:
  - Read at BASE_ADDR-4 -> r_opc=1, rdata=32'hBADACCE5.
  - Write at BASE_ADDR+NB_BANKS*BANK_WORDS*4 -> r_opc=1; a read back of row 0 is unchanged.
- Reset mid-operation:
  - Assert rst_i during INIT at count 7 -> the sweep restarts and init_done_o rises 16 cycles after release.
  - Assert rst_i with reads in flight in RUN -> no r_valid_o emerges from those reads.
